hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage MIPS core. It drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB enable-flops. It detects load-use hazards, applies taken-branch flushes, and holds the pipe while the multi-cycle multiply/divide unit is busy. A small FSM with a cycle counter sequences the mult/div stall and bounds it with a timeout.

---
 rtl/hazard_ctrl_pkg.sv | 16 +
 rtl/md_stall_fsm.sv | 70 +++++++
 rtl/hazard_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_pkg: shared types and defaults for the pipeline hazard controller.
//   md_state_t  - mult/div stall FSM states (IDLE, BUSY, DONE)
//   MD_MAX_DFLT - default BUSY-cycle bound before forced release
//   REG_W_DFLT  - default register-specifier width
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    localparam int MD_MAX_DFLT = 40;
    localparam int REG_W_DFLT  = 5;

endpackage

// File: rtl/md_stall_fsm.sv
// md_stall_fsm: sequences the pipeline hold while the mult/div unit works.
//   clk, rst_n  - clock, async active-low reset
//   md_start    - mult/div instruction sitting in EX
//   md_done     - unit result valid (1-cycle pulse)
//   md_stall    - hold the front of the pipe this cycle
//   md_busy     - FSM is in BUSY
//   md_timeout  - 1-cycle pulse when BUSY is released without md_done
module md_stall_fsm
    import hazard_pkg::*;
#(
    parameter int MD_MAX = MD_MAX_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    input  logic md_done,
    output logic md_stall,
    output logic md_busy,
    output logic md_timeout
);

    localparam int CW = $clog2(MD_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_MAX - 1);

    md_state_t       state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        md_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (md_start) begin
                    state_nx = BUSY;
                    cnt_nx   = '0;
                end
            end
            BUSY: begin
                cnt_nx = cnt + CW'(1);
                // a real completion wins over the bound in the same cycle
                if (md_done) begin
                    state_nx = DONE;
                end else if (cnt == CNT_LAST) begin
                    state_nx   = DONE;
                    md_timeout = 1'b1;
                end
            end
            // one free cycle lets the mult/div instruction leave EX while
            // md_start is still high, without retriggering
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign md_busy  = (state == BUSY);
    // the md_start term is gated so an asserted reset always frees the pipe
    assign md_stall = (rst_n & (state == IDLE) & md_start) | (state == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: enable/flush sequencing for the 5-stage MIPS pipeline.
//   clk, rst_n            - clock, async active-low reset
//   id_rs, id_rt          - sources of the instruction in ID
//   ex_memread, ex_rt     - load in EX and its destination
//   id_branch_taken       - branch resolved taken in ID
//   md_start, md_done     - mult/div in EX / result valid pulse
//   en_pc .. en_memwb     - stage register enables
//   flush_ifid/idex/exmem - bubble insert into the next stage register
//   md_busy, md_timeout   - mult/div FSM status
//   stall_cycles          - (HAZARD_CTRL_STATS_EN only) saturating count of
//                           cycles with en_pc low
// Optional feature macro: HAZARD_CTRL_STATS_EN
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_MAX = MD_MAX_DFLT,
    parameter int REG_W  = REG_W_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_branch_taken,
    input  logic             md_start,
    input  logic             md_done,
    output logic             en_pc,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             md_busy,
    output logic             md_timeout
`ifdef HAZARD_CTRL_STATS_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    logic md_stall;
    logic load_use;

    md_stall_fsm #(.MD_MAX(MD_MAX)) u_md_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .md_start   (md_start),
        .md_done    (md_done),
        .md_stall   (md_stall),
        .md_busy    (md_busy),
        .md_timeout (md_timeout)
    );

    // $zero is never a real dependency
    assign load_use = rst_n & ex_memread & (ex_rt != '0) &
                      ((ex_rt == id_rs) | (ex_rt == id_rt));

    always_comb begin
        en_pc       = 1'b1;
        en_ifid     = 1'b1;
        en_idex     = 1'b1;
        en_exmem    = 1'b1;
        en_memwb    = 1'b1;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        if (md_stall) begin
            // freeze IF..EX, let older instructions drain past EX/MEM
            en_pc       = 1'b0;
            en_ifid     = 1'b0;
            en_idex     = 1'b0;
            flush_exmem = 1'b1;
        end else if (load_use) begin
            // branch is ignored here: its operands are not ready and it is
            // re-evaluated next cycle
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
        end else if (rst_n & id_branch_taken) begin
            flush_ifid = 1'b1;
        end
    end

`ifdef HAZARD_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!en_pc && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
